// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : time_set_ctrl
// Purpose : Front-panel time setting: key debounce, edit-mode FSM, BCD field
//           increment and parallel-load strobes for the hour/min/sec counters.
// Revision: 1.0  initial release
// ============================================================================
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CP,
  input  logic       CLR,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [7:0] Q_hour,
  input  logic [7:0] Q_min,
  input  logic [7:0] Q_sec,
  output logic [7:0] D,
  output logic       Load_hour,
  output logic       Load_min,
  output logic       Load_sec,
  output logic       En_run,
  output logic [1:0] mode
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  logic [1:0] key_raw;
  logic [1:0] press_ev;
  state_t     state;
  logic [7:0] edit;
  logic [7:0] inc_val;

  assign key_raw = {key_inc, key_mode};

  // Index 0 is the mode key, index 1 the increment key.
  for (genvar i = 0; i < 2; i++) begin : g_key
    logic             sync1;
    logic             sync2;
    logic             level;
    logic             ev;
    logic [CNT_W-1:0] cnt;

    // The counter only runs while the synchronized sample disagrees with the
    // accepted level; the level flips once the disagreement has persisted.
    always_ff @(posedge CP) begin
      if (CLR) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        level <= 1'b0;
        ev    <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= key_raw[i];
        sync2 <= sync1;
        ev    <= 1'b0;
        if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          ev    <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press_ev[i] = ev;
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic is_hour);
    logic [7:0] lim;
    lim = is_hour ? 8'h23 : 8'h59;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= lim)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign inc_val = bcd_inc(edit, state == SET_HOUR);
  assign mode    = state;

  // A mode event always wins over a simultaneous inc event.
  always_ff @(posedge CP) begin
    if (CLR) begin
      state     <= RUN;
      En_run    <= 1'b1;
      D         <= 8'h00;
      edit      <= 8'h00;
      Load_hour <= 1'b0;
      Load_min  <= 1'b0;
      Load_sec  <= 1'b0;
    end else begin
      Load_hour <= 1'b0;
      Load_min  <= 1'b0;
      Load_sec  <= 1'b0;
      if (press_ev[0]) begin
        case (state)
          RUN: begin
            state  <= SET_HOUR;
            edit   <= Q_hour;
            En_run <= 1'b0;
          end
          SET_HOUR: begin
            state <= SET_MIN;
            edit  <= Q_min;
          end
          SET_MIN: begin
            state <= SET_SEC;
            edit  <= Q_sec;
          end
          default: begin
            state  <= RUN;
            En_run <= 1'b1;
          end
        endcase
      end else if (press_ev[1] && state != RUN) begin
        edit <= inc_val;
        D    <= inc_val;
        case (state)
          SET_HOUR: Load_hour <= 1'b1;
          SET_MIN:  Load_min  <= 1'b1;
          default:  Load_sec  <= 1'b1;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
